// File: rtl/output_buffer_ctrl.sv
// Per-operation sequencer for the PIM output buffer. It issues capture strobes, the processing
// window, the processing-done pulse, and the group drain over a valid/ready host handshake.
module output_buffer_ctrl #(
    parameter int NUM_GROUPS  = 32,
    parameter int PROC_CYCLES = 4,
    parameter int CNT_W       = $clog2(NUM_GROUPS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       pim_mode_i,
    input  logic [8:0]       col_addr9_i,
    input  logic             adc_valid_i,
    input  logic             abort_i,
    input  logic             zp_wr_i,
    input  logic             out_ready_i,
    output logic [2:0]       pim_mode_o,
    output logic [2:0]       before_load_mode_o,
    output logic             pim_out_buf_w_en_1_o,
    output logic             pim_out_buf_w_en_2_o,
    output logic             read_mode_buf_w_en_o,
    output logic [8:0]       col_addr9_o,
    output logic             pim_out_buf_r_en_o,
    output logic             output_processing_done_o,
    output logic             zp_en_o,
    output logic             load_en_o,
    output logic [CNT_W-1:0] load_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [2:0] MODE_READ     = 3'b011;
    localparam logic [2:0] MODE_PARALLEL = 3'b101;
    localparam logic [2:0] MODE_RBR      = 3'b110;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CAP1  = 3'd1;
    localparam logic [2:0] ST_CAP2  = 3'd2;
    localparam logic [2:0] ST_PROC  = 3'd3;
    localparam logic [2:0] ST_PDONE = 3'd4;
    localparam logic [2:0] ST_RCAP  = 3'd5;
    localparam logic [2:0] ST_LOAD  = 3'd6;

    localparam int                PCNT_W    = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;
    localparam logic [PCNT_W-1:0] PROC_LAST = PCNT_W'(PROC_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_GROUPS - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [PCNT_W-1:0] proc_cnt;
    logic [PCNT_W-1:0] proc_cnt_nxt;

    logic [2:0]        pim_mode_nxt;
    logic [2:0]        before_load_mode_nxt;
    logic [8:0]        col_addr9_nxt;
    logic              w_en_1_nxt;
    logic              w_en_2_nxt;
    logic              read_w_en_nxt;
    logic              r_en_nxt;
    logic              proc_done_nxt;
    logic              load_en_nxt;
    logic [CNT_W-1:0]  load_cnt_nxt;
    logic              done_nxt;
    logic              err_nxt;

    function automatic logic mode_is_legal(input logic [2:0] mode);
        return (mode == MODE_READ) || (mode == MODE_PARALLEL) || (mode == MODE_RBR);
    endfunction

    // A READ op drains a single word; grouped ops finish on the last mapping group.
    function automatic logic is_last_word(input logic [2:0] mode, input logic [CNT_W-1:0] cnt);
        return (mode == MODE_READ) || (cnt == CNT_LAST);
    endfunction

    // Zero-point writes are only meaningful while no op owns the mapping groups.
    assign zp_en_o = zp_wr_i && (state == ST_IDLE) && !rst_i;

    always_comb begin
        state_nxt            = state;
        proc_cnt_nxt         = proc_cnt;
        pim_mode_nxt         = pim_mode_o;
        before_load_mode_nxt = before_load_mode_o;
        col_addr9_nxt        = col_addr9_o;
        w_en_1_nxt           = 1'b0;
        w_en_2_nxt           = 1'b0;
        read_w_en_nxt        = 1'b0;
        r_en_nxt             = pim_out_buf_r_en_o;
        proc_done_nxt        = 1'b0;
        load_en_nxt          = load_en_o;
        load_cnt_nxt         = load_cnt_o;
        done_nxt             = 1'b0;
        err_nxt              = 1'b0;

        if (abort_i && (state != ST_IDLE)) begin
            state_nxt    = ST_IDLE;
            proc_cnt_nxt = '0;
            r_en_nxt     = 1'b0;
            load_en_nxt  = 1'b0;
            load_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (mode_is_legal(pim_mode_i)) begin
                            pim_mode_nxt  = pim_mode_i;
                            col_addr9_nxt = col_addr9_i;
                            state_nxt     = (pim_mode_i == MODE_READ) ? ST_RCAP : ST_CAP1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                ST_CAP1: begin
                    if (adc_valid_i) begin
                        w_en_1_nxt = 1'b1;
                        state_nxt  = ST_CAP2;
                    end
                end
                ST_CAP2: begin
                    if (adc_valid_i) begin
                        w_en_2_nxt   = 1'b1;
                        r_en_nxt     = 1'b1;
                        proc_cnt_nxt = '0;
                        state_nxt    = ST_PROC;
                    end
                end
                ST_PROC: begin
                    if (proc_cnt == PROC_LAST) begin
                        r_en_nxt      = 1'b0;
                        proc_done_nxt = 1'b1;
                        state_nxt     = ST_PDONE;
                    end else begin
                        proc_cnt_nxt = proc_cnt + PCNT_W'(1);
                    end
                end
                ST_PDONE: begin
                    load_en_nxt          = 1'b1;
                    load_cnt_nxt         = '0;
                    before_load_mode_nxt = pim_mode_o;
                    state_nxt            = ST_LOAD;
                end
                ST_RCAP: begin
                    if (adc_valid_i) begin
                        read_w_en_nxt        = 1'b1;
                        load_en_nxt          = 1'b1;
                        load_cnt_nxt         = '0;
                        before_load_mode_nxt = pim_mode_o;
                        state_nxt            = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (out_ready_i) begin
                        if (is_last_word(pim_mode_o, load_cnt_o)) begin
                            done_nxt     = 1'b1;
                            load_en_nxt  = 1'b0;
                            load_cnt_nxt = '0;
                            state_nxt    = ST_IDLE;
                        end else begin
                            load_cnt_nxt = load_cnt_o + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    proc_cnt_nxt = '0;
                    r_en_nxt     = 1'b0;
                    load_en_nxt  = 1'b0;
                    load_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                    <= ST_IDLE;
            proc_cnt                 <= '0;
            pim_mode_o               <= '0;
            before_load_mode_o       <= '0;
            col_addr9_o              <= '0;
            pim_out_buf_w_en_1_o     <= 1'b0;
            pim_out_buf_w_en_2_o     <= 1'b0;
            read_mode_buf_w_en_o     <= 1'b0;
            pim_out_buf_r_en_o       <= 1'b0;
            output_processing_done_o <= 1'b0;
            load_en_o                <= 1'b0;
            load_cnt_o               <= '0;
            busy_o                   <= 1'b0;
            done_o                   <= 1'b0;
            err_o                    <= 1'b0;
        end else begin
            state                    <= state_nxt;
            proc_cnt                 <= proc_cnt_nxt;
            pim_mode_o               <= pim_mode_nxt;
            before_load_mode_o       <= before_load_mode_nxt;
            col_addr9_o              <= col_addr9_nxt;
            pim_out_buf_w_en_1_o     <= w_en_1_nxt;
            pim_out_buf_w_en_2_o     <= w_en_2_nxt;
            read_mode_buf_w_en_o     <= read_w_en_nxt;
            pim_out_buf_r_en_o       <= r_en_nxt;
            output_processing_done_o <= proc_done_nxt;
            load_en_o                <= load_en_nxt;
            load_cnt_o               <= load_cnt_nxt;
            busy_o                   <= (state_nxt != ST_IDLE);
            done_o                   <= done_nxt;
            err_o                    <= err_nxt;
        end
    end

    // Processing and draining are mutually exclusive phases of one op.
    a_phase_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pim_out_buf_r_en_o && load_en_o));
    a_cnt_idle_zero: assert property (@(posedge clk_i) disable iff (rst_i)
        !load_en_o |-> (load_cnt_o == '0));
    a_err_not_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        err_o |-> !busy_o);

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Randomized scoreboard bench for output_buffer_ctrl with directed boundary scenarios.
module tb_output_buffer_ctrl;

    localparam int         NUM_GROUPS  = 32;
    localparam int         PROC_CYCLES = 4;
    localparam int         CNT_W       = 5;
    localparam logic [2:0] M_READ      = 3'b011;
    localparam logic [2:0] M_PAR       = 3'b101;
    localparam logic [2:0] M_RBR       = 3'b110;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic [2:0]       pim_mode_i = '0;
    logic [8:0]       col_addr9_i = '0;
    logic             adc_valid_i = 1'b0;
    logic             abort_i = 1'b0;
    logic             zp_wr_i = 1'b0;
    logic             out_ready_i = 1'b0;
    logic [2:0]       pim_mode_o;
    logic [2:0]       before_load_mode_o;
    logic             pim_out_buf_w_en_1_o;
    logic             pim_out_buf_w_en_2_o;
    logic             read_mode_buf_w_en_o;
    logic [8:0]       col_addr9_o;
    logic             pim_out_buf_r_en_o;
    logic             output_processing_done_o;
    logic             zp_en_o;
    logic             load_en_o;
    logic [CNT_W-1:0] load_cnt_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    output_buffer_ctrl #(
        .NUM_GROUPS (NUM_GROUPS),
        .PROC_CYCLES(PROC_CYCLES)
    ) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .start_i                 (start_i),
        .pim_mode_i              (pim_mode_i),
        .col_addr9_i             (col_addr9_i),
        .adc_valid_i             (adc_valid_i),
        .abort_i                 (abort_i),
        .zp_wr_i                 (zp_wr_i),
        .out_ready_i             (out_ready_i),
        .pim_mode_o              (pim_mode_o),
        .before_load_mode_o      (before_load_mode_o),
        .pim_out_buf_w_en_1_o    (pim_out_buf_w_en_1_o),
        .pim_out_buf_w_en_2_o    (pim_out_buf_w_en_2_o),
        .read_mode_buf_w_en_o    (read_mode_buf_w_en_o),
        .col_addr9_o             (col_addr9_o),
        .pim_out_buf_r_en_o      (pim_out_buf_r_en_o),
        .output_processing_done_o(output_processing_done_o),
        .zp_en_o                 (zp_en_o),
        .load_en_o               (load_en_o),
        .load_cnt_o              (load_cnt_o),
        .busy_o                  (busy_o),
        .done_o                  (done_o),
        .err_o                   (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0] mode;
        int         cnt;
        bit         is_last;
    } xfer_t;

    xfer_t      xfer_q[$];
    bit         exp_done_pending = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [2:0] ill_modes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [2:0] m);
        return (m == M_READ) || (m == M_PAR) || (m == M_RBR);
    endfunction

    function automatic logic [29:0] all_outs();
        return {pim_mode_o, before_load_mode_o, pim_out_buf_w_en_1_o, pim_out_buf_w_en_2_o,
                read_mode_buf_w_en_o, col_addr9_o, pim_out_buf_r_en_o, output_processing_done_o,
                zp_en_o, load_en_o, load_cnt_o, busy_o, done_o, err_o};
    endfunction

    // Scoreboard monitor: every accepted host beat must match the next expected word.
    always @(negedge clk_i) begin
        xfer_t rec;
        if (!rst_i) begin
            chk("done_o_pulse", 32'(done_o), 32'(exp_done_pending));
            if (exp_done_pending) begin
                chk("load_en_after_last", 32'(load_en_o), 0);
                chk("load_cnt_after_last", 32'(load_cnt_o), 0);
                exp_done_pending = 1'b0;
            end
            if (load_en_o && out_ready_i && !abort_i) begin
                chk("xfer_expected", 32'(xfer_q.size() != 0), 1);
                if (xfer_q.size() != 0) begin
                    rec = xfer_q.pop_front();
                    chk("xfer_mode", 32'(before_load_mode_o), 32'(rec.mode));
                    chk("xfer_cnt", 32'(load_cnt_o), rec.cnt);
                    if (rec.is_last) exp_done_pending = 1'b1;
                end
            end
        end
    end

    task automatic pulse_adc(input int gap);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk_i); #1;
            chk("cap_idle", 32'({pim_out_buf_w_en_1_o, pim_out_buf_w_en_2_o,
                                 read_mode_buf_w_en_o}), 0);
        end
        adc_valid_i = 1'b1;
        @(posedge clk_i); #1;
        adc_valid_i = 1'b0;
    endtask

    task automatic start_capture(input logic [2:0] mode, input logic [8:0] col,
                                 input int g1, input int g2, output bit ok);
        int n;
        ok = legal(mode);
        if (ok) begin
            for (int k = 0; k < ((mode == M_READ) ? 1 : NUM_GROUPS); k++)
                xfer_q.push_back('{mode, k, (mode == M_READ) || (k == NUM_GROUPS - 1)});
        end
        start_i = 1'b1; pim_mode_i = mode; col_addr9_i = col;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        if (!ok) begin
            chk("err_pulse", 32'(err_o), 1);
            chk("err_busy", 32'(busy_o), 0);
            @(posedge clk_i); #1;
            chk("err_single", 32'(err_o), 0);
            chk("err_busy2", 32'(busy_o), 0);
            return;
        end
        chk("start_busy", 32'(busy_o), 1);
        chk("start_mode", 32'(pim_mode_o), 32'(mode));
        chk("start_col", 32'(col_addr9_o), 32'(col));
        if (mode == M_READ) begin
            pulse_adc(g1);
            chk("read_w_en", 32'(read_mode_buf_w_en_o), 1);
            chk("read_load_en", 32'(load_en_o), 1);
            chk("read_blm", 32'(before_load_mode_o), 32'(mode));
            chk("read_cnt0", 32'(load_cnt_o), 0);
        end else begin
            pulse_adc(g1);
            chk("w_en_1", 32'({pim_out_buf_w_en_1_o, pim_out_buf_w_en_2_o}), 32'b10);
            pulse_adc(g2);
            chk("w_en_2", 32'({pim_out_buf_w_en_1_o, pim_out_buf_w_en_2_o}), 32'b01);
            n = 0;
            while (pim_out_buf_r_en_o && n < 64) begin
                n++;
                @(posedge clk_i); #1;
            end
            chk("r_en_len", n, PROC_CYCLES);
            chk("proc_done", 32'(output_processing_done_o), 1);
            chk("proc_no_load", 32'(load_en_o), 0);
            @(posedge clk_i); #1;
            chk("proc_done_single", 32'(output_processing_done_o), 0);
            chk("load_entry", 32'(load_en_o), 1);
            chk("load_blm", 32'(before_load_mode_o), 32'(mode));
            chk("load_cnt0", 32'(load_cnt_o), 0);
        end
    endtask

    // rmode: 0 always ready, 1 random ready, 2 ready pattern 1,0,0,1.
    task automatic drain(input int rmode);
        bit seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            case (rmode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = 1'($urandom_range(0, 1));
                default: out_ready_i = ((c % 4) == 0) || ((c % 4) == 3);
            endcase
            adc_valid_i = 1'($urandom_range(0, 1));
            start_i     = 1'($urandom_range(0, 1));
            pim_mode_i  = 3'($urandom);
            @(posedge clk_i); #1;
            if (done_o) seen = 1'b1;
            chk("drain_quiet", 32'({pim_out_buf_w_en_1_o, pim_out_buf_w_en_2_o,
                                    read_mode_buf_w_en_o, pim_out_buf_r_en_o,
                                    output_processing_done_o, err_o}), 0);
            chk("drain_busy", 32'(busy_o), seen ? 0 : 1);
        end
        out_ready_i = 1'b0; adc_valid_i = 1'b0; start_i = 1'b0;
        chk("drain_finished", 32'(seen), 1);
    endtask

    task automatic run_op(input logic [2:0] mode, input logic [8:0] col,
                          input int g1, input int g2, input int rmode);
        bit ok;
        start_capture(mode, col, g1, g2, ok);
        if (ok) begin
            drain(rmode);
            chk("blm_hold", 32'(before_load_mode_o), 32'(mode));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         r;
        logic [2:0] m;
        int         n;

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_outputs", 32'(all_outs()), 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("idle_outputs", 32'(all_outs()), 0);

        zp_wr_i = 1'b1; #1;
        chk("zp_idle", 32'(zp_en_o), 1);
        zp_wr_i = 1'b0;
        @(posedge clk_i); #1;

        run_op(M_PAR, 9'h055, 2, 3, 0);

        start_capture(M_READ, 9'h1A5, 2, 0, ok);
        zp_wr_i = 1'b1; #1;
        chk("zp_load_blocked", 32'(zp_en_o), 0);
        zp_wr_i = 1'b0;
        drain(0);
        chk("read_blm_hold", 32'(before_load_mode_o), 32'(M_READ));
        chk("read_col_hold", 32'(col_addr9_o), 32'h1A5);

        run_op(M_RBR, 9'h000, 1, 1, 2);
        run_op(3'b001, 9'h1FF, 1, 1, 0);

        // Abort mid-drain, then a clean op.
        start_capture(M_PAR, 9'h0F0, 1, 2, ok);
        out_ready_i = 1'b1;
        n = 0;
        while (load_cnt_o != CNT_W'(10) && n < 100) begin
            n++;
            @(posedge clk_i); #1;
        end
        chk("abort_reach_cnt10", 32'(load_cnt_o), 10);
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0; out_ready_i = 1'b0;
        chk("abort_load_en", 32'(load_en_o), 0);
        chk("abort_cnt", 32'(load_cnt_o), 0);
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_no_done", 32'(done_o), 0);
        xfer_q.delete();
        @(posedge clk_i); #1;
        run_op(M_PAR, 9'h133, 1, 1, 1);

        // Asynchronous reset during processing.
        start_i = 1'b1; pim_mode_i = M_PAR; col_addr9_i = 9'h077;
        xfer_q.push_back('{M_PAR, 0, 1'b0});
        @(posedge clk_i); #1;
        start_i = 1'b0;
        pulse_adc(1);
        pulse_adc(1);
        chk("rst_in_proc", 32'(pim_out_buf_r_en_o), 1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_async_outputs", 32'(all_outs()), 0);
        xfer_q.delete();
        exp_done_pending = 1'b0;
        start_i = 1'b1; pim_mode_i = M_PAR;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("rst_start_ignored", 32'(busy_o), 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("post_rst_outputs", 32'(all_outs()), 0);
        run_op(M_RBR, 9'h0AA, 2, 1, 0);

        for (int i = 0; i < 25; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      m = ill_modes[$urandom_range(0, 4)];
            else if (r < 4)  m = M_READ;
            else if (r < 7)  m = M_PAR;
            else             m = M_RBR;
            run_op(m, 9'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                   int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #1;
        end

        repeat (3) @(posedge clk_i);
        #1;
        chk("scoreboard_empty", 32'(xfer_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
